uart_alu_intf_gen: RTL and testbench

Parametrised successor to the single-byte UART/ALU interface. It assembles multi-byte operands A and B and an opcode byte from UART RX frames and drives them to the ALU. It then serialises the ALU result back to UART TX as multiple bytes using a done-handshake, and recovers from stalled transfers with a timeout. It sits between UART_RX/UART_TX and the ALU, all on one clock.

---
 rtl/uart_alu_intf_gen.sv | 202 ++++++++++++++++++++
 tb/tb_uart_alu_intf_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_intf_gen.sv
// Bridges UART RX/TX and the ALU: gathers multi-byte operands and an opcode from RX frames,
// then streams the ALU result back out to TX one byte at a time, with a stall timeout.
module uart_alu_intf_gen #(
    parameter int unsigned SIZEDATA       = 8,
    parameter int unsigned SIZEOP         = 6,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_rx_done,
    input  logic [7:0]          i_rx_data,
    input  logic [SIZEDATA-1:0] i_alu_result,
    input  logic                i_tx_done,
    output logic [SIZEDATA-1:0] o_alu_datoa,
    output logic [SIZEDATA-1:0] o_alu_datob,
    output logic [SIZEOP-1:0]   o_alu_opcode,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_signal,
    output logic                o_busy,
    output logic                o_timeout_err
);

    localparam int unsigned NBYTES = (SIZEDATA + 7) / 8;
    localparam int unsigned BW     = NBYTES * 8;
    localparam int unsigned CW     = $clog2(NBYTES + 1);
    localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] LastByte = CW'(NBYTES - 1);
    localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StRxA,
        StRxB,
        StRxOp,
        StAluWait,
        StTxSend,
        StTxWait
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [BW-1:0]         shadow_q, shadow_d;
    logic [BW-1:0]         res_q, res_d;
    logic [SIZEDATA-1:0]   datoa_q, datoa_d;
    logic [SIZEDATA-1:0]   datob_q, datob_d;
    logic [SIZEOP-1:0]     opcode_q, opcode_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic [BW-1:0]         rx_shift;
    logic [BW-1:0]         alu_ext;
    logic                  count_en;
    logic                  last_rx_byte;

    // New byte enters at the top so the first byte received ends up in the LSB position.
    assign rx_shift     = (shadow_q >> 8) | (BW'(i_rx_data) << (BW - 8));
    assign alu_ext      = BW'(i_alu_result);
    assign last_rx_byte = (byte_cnt_q == LastByte);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        shadow_d   = shadow_q;
        res_d      = res_q;
        datoa_d    = datoa_q;
        datob_d    = datob_q;
        opcode_d   = opcode_q;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        err_d      = err_q;
        count_en   = 1'b0;

        unique case (state_q)
            StRxA: begin
                if (i_rx_done) begin
                    tmo_d    = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    shadow_d = rx_shift;
                    if (last_rx_byte) begin
                        byte_cnt_d = '0;
                        datoa_d    = rx_shift[SIZEDATA-1:0];
                        state_d    = StRxB;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else if (byte_cnt_q == '0) begin
                    // Idle: nothing to time out on.
                    tmo_d = '0;
                end else begin
                    count_en = 1'b1;
                end
            end
            StRxB: begin
                if (i_rx_done) begin
                    tmo_d    = '0;
                    shadow_d = rx_shift;
                    if (last_rx_byte) begin
                        byte_cnt_d = '0;
                        datob_d    = rx_shift[SIZEDATA-1:0];
                        state_d    = StRxOp;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else begin
                    count_en = 1'b1;
                end
            end
            StRxOp: begin
                if (i_rx_done) begin
                    tmo_d    = '0;
                    opcode_d = i_rx_data[SIZEOP-1:0];
                    state_d  = StAluWait;
                end else begin
                    count_en = 1'b1;
                end
            end
            StAluWait: begin
                tx_data_d  = alu_ext[7:0];
                res_d      = alu_ext >> 8;
                byte_cnt_d = '0;
                tmo_d      = '0;
                state_d    = StTxSend;
            end
            StTxSend: begin
                tmo_d   = '0;
                state_d = StTxWait;
            end
            StTxWait: begin
                if (i_tx_done) begin
                    if (last_rx_byte) begin
                        byte_cnt_d = '0;
                        busy_d     = 1'b0;
                        state_d    = StRxA;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        tx_data_d  = res_q[7:0];
                        res_d      = res_q >> 8;
                        state_d    = StTxSend;
                    end
                end else begin
                    count_en = 1'b1;
                end
            end
            default: state_d = StRxA;
        endcase

        // Only reached when no byte/handshake arrived this cycle, so an abort never loses data.
        if (count_en) begin
            if (tmo_q == TmoLast) begin
                err_d      = 1'b1;
                busy_d     = 1'b0;
                byte_cnt_d = '0;
                tmo_d      = '0;
                shadow_d   = '0;
                state_d    = StRxA;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= StRxA;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            shadow_q   <= '0;
            res_q      <= '0;
            datoa_q    <= '0;
            datob_q    <= '0;
            opcode_q   <= '0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            shadow_q   <= shadow_d;
            res_q      <= res_d;
            datoa_q    <= datoa_d;
            datob_q    <= datob_d;
            opcode_q   <= opcode_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign o_alu_datoa   = datoa_q;
    assign o_alu_datob   = datob_q;
    assign o_alu_opcode  = opcode_q;
    assign o_tx_data     = tx_data_q;
    assign o_tx_signal   = (state_q == StTxSend);
    assign o_busy        = busy_q;
    assign o_timeout_err = err_q;

endmodule

// File: tb/tb_uart_alu_intf_gen.sv
// Scoreboard bench for uart_alu_intf_gen with 16-bit operands and a short timeout.
module tb_uart_alu_intf_gen;

    localparam int unsigned SIZEDATA = 16;
    localparam int unsigned SIZEOP   = 6;
    localparam int unsigned TMO      = 100;

    logic                clk;
    logic                reset;
    logic                rx_done;
    logic [7:0]          rx_data;
    logic [SIZEDATA-1:0] alu_result;
    logic                tx_done;
    logic [SIZEDATA-1:0] datoa;
    logic [SIZEDATA-1:0] datob;
    logic [SIZEOP-1:0]   opcode;
    logic [7:0]          tx_data;
    logic                tx_signal;
    logic                busy;
    logic                timeout_err;

    int   checks   = 0;
    int   failures = 0;
    bit   withhold = 1'b0;
    logic [7:0] exp_q[$];

    uart_alu_intf_gen #(
        .SIZEDATA      (SIZEDATA),
        .SIZEOP        (SIZEOP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clock      (clk),
        .i_reset      (reset),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_alu_result (alu_result),
        .i_tx_done    (tx_done),
        .o_alu_datoa  (datoa),
        .o_alu_datob  (datob),
        .o_alu_opcode (opcode),
        .o_tx_data    (tx_data),
        .o_tx_signal  (tx_signal),
        .o_busy       (busy),
        .o_timeout_err(timeout_err)
    );

    // Stand-in ALU fed by the DUT's registered operands.
    always_comb begin
        alu_result = '0;
        case (opcode)
            6'h20:   alu_result = datoa + datob;
            6'h22:   alu_result = datoa - datob;
            6'h24:   alu_result = datoa & datob;
            6'h25:   alu_result = datoa | datob;
            default: alu_result = '0;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every TX start pulse must match the next queued byte.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_signal === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected actual=0x%0h required=no_pulse", tx_data);
                end else begin
                    check("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // UART_TX model: acknowledges each frame a few cycles after its start pulse.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_signal === 1'b1 && !withhold) begin
                repeat (3) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, {31'h0, busy}, 32'h0);
    endtask

    task automatic run_txn(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] op,
                           input logic [15:0] exp_res, input int n_exp, input bit inject);
        exp_q.push_back(exp_res[7:0]);
        if (n_exp > 1) exp_q.push_back(exp_res[15:8]);
        send_byte(a0);
        check("busy_first_byte", {31'h0, busy}, 32'h1);
        check("err_first_byte", {31'h0, timeout_err}, 32'h0);
        send_byte(a1);
        check("datoa", {16'h0, datoa}, {16'h0, a1, a0});
        send_byte(b0);
        send_byte(b1);
        check("datob", {16'h0, datob}, {16'h0, b1, b0});
        send_byte(op);
        check("opcode", {26'h0, opcode}, {26'h0, op[5:0]});
        check("tx_sig_n1", {31'h0, tx_signal}, 32'h0);
        @(posedge clk);
        #1;
        check("tx_sig_n2", {31'h0, tx_signal}, 32'h1);
        if (inject) begin
            send_byte(8'h77);
            @(posedge clk);
            #1;
            check("datoa_inject", {16'h0, datoa}, {16'h0, a1, a0});
            check("datob_inject", {16'h0, datob}, {16'h0, b1, b0});
        end
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_datoa", {16'h0, datoa}, 32'h0);
        check("rst_tx_signal", {31'h0, tx_signal}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, timeout_err}, 32'h0);
        reset = 1'b0;

        // ADD 0x0102 + 0x0304 = 0x0406
        run_txn(8'h02, 8'h01, 8'h04, 8'h03, 8'h20, 16'h0406, 2, 1'b0);
        wait_idle("idle_add");
        // SUB 0x0010 - 0x0003 = 0x000D
        run_txn(8'h10, 8'h00, 8'h03, 8'h00, 8'h22, 16'h000D, 2, 1'b0);
        wait_idle("idle_sub");
        // AND with upper opcode bits set: 0xE4 -> opcode 0x24; 0xF0F0 & 0x3C3C = 0x3030
        run_txn(8'hF0, 8'hF0, 8'h3C, 8'h3C, 8'hE4, 16'h3030, 2, 1'b0);
        wait_idle("idle_and");

        // RX stall: one byte of A, then silence until the abort.
        send_byte(8'h11);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("err_before_expiry", {31'h0, timeout_err}, 32'h0);
        @(posedge clk);
        #1;
        check("err_at_expiry", {31'h0, timeout_err}, 32'h1);
        check("busy_after_abort", {31'h0, busy}, 32'h0);
        check("datoa_kept", {16'h0, datoa}, 32'h0000F0F0);
        run_txn(8'h05, 8'h00, 8'h03, 8'h00, 8'h20, 16'h0008, 2, 1'b0);
        wait_idle("idle_after_rx_tmo");

        // Second byte of A lands exactly on the expiry cycle: accepted, no error.
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        send_byte(8'h00);
        repeat (TMO - 2) @(posedge clk);
        send_byte(8'h12);
        check("err_coincident", {31'h0, timeout_err}, 32'h0);
        check("datoa_coincident", {16'h0, datoa}, 32'h00001200);
        send_byte(8'h34);
        send_byte(8'h00);
        send_byte(8'h25);
        wait_idle("idle_coincident");

        // TX stall: no i_tx_done after the first pulse.
        withhold = 1'b1;
        run_txn(8'h01, 8'h00, 8'h01, 8'h00, 8'h20, 16'h0002, 1, 1'b0);
        n = 0;
        while (!timeout_err && n < 150) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("err_tx_stall", {31'h0, timeout_err}, 32'h1);
        check("busy_tx_stall", {31'h0, busy}, 32'h0);
        repeat (20) @(posedge clk);
        #1;
        withhold = 1'b0;

        // Reset in the middle of operand B.
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_datoa", {16'h0, datoa}, 32'h0);
        check("mid_rst_datob", {16'h0, datob}, 32'h0);
        check("mid_rst_opcode", {26'h0, opcode}, 32'h0);
        check("mid_rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_err", {31'h0, timeout_err}, 32'h0);
        reset = 1'b0;
        run_txn(8'h01, 8'h00, 8'h01, 8'h00, 8'h20, 16'h0002, 2, 1'b0);
        wait_idle("idle_after_reset");

        // Stray RX byte during TX_WAIT must be dropped.
        run_txn(8'h02, 8'h01, 8'h04, 8'h03, 8'h20, 16'h0406, 2, 1'b1);
        wait_idle("idle_inject");
        // Alignment after the dropped byte: 0x0100 - 0x0001 = 0x00FF
        run_txn(8'h00, 8'h01, 8'h01, 8'h00, 8'h22, 16'h00FF, 2, 1'b0);
        wait_idle("idle_final");

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
